// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. It requests one word at a time from instruction
//   memory, holds the returned instruction for the decoder, slices out the
//   register/function fields and immediates, and computes the next PC when
//   the decoder retires the held instruction.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   imem_req/addr   fetch request and address (address is always pc)
//   imem_rdata/ack  returned instruction word and its one-cycle strobe
//   enpc            retire the held instruction and advance the PC
//   jal, jalr, b    control-transfer selects from the decoder
//   flag            ALU compare result, qualifies b
//   rs1_data        register read data used as the jalr base
//   instr/valid     held instruction and its valid flag
//   opcode..func7   field slices of instr
//   imm_i/b/j       sign-extended immediates of instr
//   pc, pc_plus4    address of the held instruction and its link value
//   misalign        one-cycle pulse when a target was misaligned and
//                   the trap vector was loaded instead
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        enpc,
  input  logic        jal,
  input  logic        jalr,
  input  logic        b,
  input  logic        flag,
  input  logic [31:0] rs1_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm_i,
  output logic [31:0] imm_b,
  output logic [31:0] imm_j,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  state_t      state_next;
  logic        retire;
  logic [31:0] target;
  logic [31:0] jalr_sum;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= START;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; acks outside FETCH fall through untouched
  always_comb begin
    state_next = state;
    case (state)
      START:   state_next = FETCH;
      FETCH:   if (imem_ack) state_next = EXEC;
      EXEC:    if (enpc) state_next = FETCH;
      default: state_next = START;
    endcase
  end

  // Moore outputs of the FSM
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH:   imem_req = 1'b1;
      EXEC:    instr_valid = 1'b1;
      default: ;
    endcase
  end

  assign retire = (state == EXEC) && enpc;

  // Field slices and immediates straight off the instruction register
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign func3  = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign func7  = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                  instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                  instr[30:21], 1'b0};

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign jalr_sum  = rs1_data + imm_i;

  // Target selection: jalr beats jal beats a taken branch; jalr drops bit 0
  always_comb begin
    target = pc_plus4;
    if (jalr) begin
      target = {jalr_sum[31:1], 1'b0};
    end else if (jal) begin
      target = pc + imm_j;
    end else if (b && flag) begin
      target = pc + imm_b;
    end
  end

  // PC, instruction latch and misalign pulse. A target with bit 1 set is
  // redirected to the trap vector and flagged for the following cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= NOP;
      misalign <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (state == FETCH && imem_ack) begin
        instr <= imem_rdata;
      end
      if (retire) begin
        if (target[1]) begin
          pc       <= TRAP_PC;
          misalign <= 1'b1;
        end else begin
          pc <= target;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural model follows the
//   fetch/execute protocol and is compared against every DUT output on each
//   falling edge. Directed sequences pin the model with literal values, and a
//   randomized phase then exercises acks, retires, jumps, branches and resets.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] TRAP    = 32'h0000_0200;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          P_START = 0;
  localparam int          P_FETCH = 1;
  localparam int          P_EXEC  = 2;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        enpc;
  logic        jal;
  logic        jalr;
  logic        b;
  logic        flag;
  logic [31:0] rs1_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;

  int nAsserts = 0;
  int nFails   = 0;

  fetch_unit #(
    .RESET_PC(RST_PC),
    .TRAP_PC (TRAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .enpc       (enpc),
    .jal        (jal),
    .jalr       (jalr),
    .b          (b),
    .flag       (flag),
    .rs1_data   (rs1_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .func3      (func3),
    .func7      (func7),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm_i      (imm_i),
    .imm_b      (imm_b),
    .imm_j      (imm_j),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Immediates computed by arithmetic sign extension of a left-aligned field
  function automatic logic [31:0] modelImmI(input logic [31:0] w);
    return 32'($signed(w) >>> 20);
  endfunction

  function automatic logic [31:0] modelImmB(input logic [31:0] w);
    logic [12:0] f;
    logic [31:0] t;
    f = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    t = {f, 19'b0};
    return 32'($signed(t) >>> 19);
  endfunction

  function automatic logic [31:0] modelImmJ(input logic [31:0] w);
    logic [20:0] f;
    logic [31:0] t;
    f = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    t = {f, 11'b0};
    return 32'($signed(t) >>> 11);
  endfunction

  // Behavioural model state
  int          mPhase = P_START;
  logic [31:0] mPc    = 32'h0;
  logic [31:0] mInstr = NOP;
  logic        mMis   = 1'b0;
  bit          modelReady = 1'b0;

  // Model advances on each rising edge from the inputs present at that edge
  always @(posedge clk) begin
    logic [31:0] tgt;
    if (rst) begin
      mPhase     = P_START;
      mPc        = RST_PC;
      mInstr     = NOP;
      mMis       = 1'b0;
      modelReady = 1'b1;
    end else begin
      mMis = 1'b0;
      if (mPhase == P_START) begin
        mPhase = P_FETCH;
      end else if (mPhase == P_FETCH) begin
        if (imem_ack) begin
          mInstr = imem_rdata;
          mPhase = P_EXEC;
        end
      end else if (enpc) begin
        if (jalr)
          tgt = (rs1_data + modelImmI(mInstr)) & 32'hFFFF_FFFE;
        else if (jal)
          tgt = mPc + modelImmJ(mInstr);
        else if (b && flag)
          tgt = mPc + modelImmB(mInstr);
        else
          tgt = mPc + 32'd4;
        if (tgt[1]) begin
          mPc  = TRAP;
          mMis = 1'b1;
        end else begin
          mPc = tgt;
        end
        mPhase = P_FETCH;
      end
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("imem_req",    32'(imem_req),    32'(mPhase == P_FETCH));
      checkOutput("imem_addr",   imem_addr,        mPc);
      checkOutput("instr_valid", 32'(instr_valid), 32'(mPhase == P_EXEC));
      checkOutput("pc",          pc,               mPc);
      checkOutput("pc_plus4",    pc_plus4,         mPc + 32'd4);
      checkOutput("misalign",    32'(misalign),    32'(mMis));
      checkOutput("instr",       instr,            mInstr);
      checkOutput("opcode",      32'(opcode),      32'(mInstr & 32'h7F));
      checkOutput("rd",          32'(rd),          (mInstr >> 7) & 32'h1F);
      checkOutput("func3",       32'(func3),       (mInstr >> 12) & 32'h7);
      checkOutput("rs1",         32'(rs1),         (mInstr >> 15) & 32'h1F);
      checkOutput("rs2",         32'(rs2),         (mInstr >> 20) & 32'h1F);
      checkOutput("func7",       32'(func7),       mInstr >> 25);
      checkOutput("imm_i",       imm_i,            modelImmI(mInstr));
      checkOutput("imm_b",       imm_b,            modelImmB(mInstr));
      checkOutput("imm_j",       imm_j,            modelImmJ(mInstr));
    end
  end

  // One clock step; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic a,
                               input logic [31:0] data, input logic en,
                               input logic j, input logic jr,
                               input logic br, input logic fl,
                               input logic [31:0] rs);
    rst        = r;
    imem_ack   = a;
    imem_rdata = data;
    enpc       = en;
    jal        = j;
    jalr       = jr;
    b          = br;
    flag       = fl;
    rs1_data   = rs;
    tick();
  endtask

  // Wait (bounded) for a request, stall some cycles, then return one word
  task automatic fetchWith(input logic [31:0] word, input int waits);
    int guard;
    guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard == 20) checkOutput("fetch_wait_timeout", 32'd0, 32'd1);
    repeat (waits) applyStimulus(0, 0, 32'hDEAD_0000, 1, 1, 1, 1, 1, 32'h3);
    applyStimulus(0, 1, word, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic retire(input logic j, input logic jr, input logic br,
                        input logic fl, input logic [31:0] rs);
    applyStimulus(0, 0, 32'h0, 1, j, jr, br, fl, rs);
    enpc = 1'b0; jal = 1'b0; jalr = 1'b0; b = 1'b0; flag = 1'b0;
  endtask

  initial begin
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    tick();
    $display("[TB] reset checks");
    checkOutput("rst_pc",       pc,                 32'h0);
    checkOutput("rst_instr",    instr,              32'h13);
    checkOutput("rst_valid",    32'(instr_valid),   32'd0);
    checkOutput("rst_req",      32'(imem_req),      32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("post_rst_req", 32'(imem_req),      32'd1);
    checkOutput("post_rst_addr", imem_addr,         32'h0);

    $display("[TB] sequential fetch");
    fetchWith(32'h0050_0093, 3);
    checkOutput("seq_valid",    32'(instr_valid),   32'd1);
    checkOutput("seq_rd",       32'(rd),            32'd1);
    checkOutput("seq_imm_i",    imm_i,              32'd5);
    retire(0, 0, 0, 0, 32'h0);
    checkOutput("seq_pc",       pc,                 32'h4);
    checkOutput("seq_req",      32'(imem_req),      32'd1);
    checkOutput("seq_addr",     imem_addr,          32'h4);

    $display("[TB] jal");
    repeat (3) begin
      fetchWith(NOP, 0);
      retire(0, 0, 0, 0, 32'h0);
    end
    checkOutput("jal_pc_before", pc,                32'h10);
    fetchWith(32'h0080_00EF, 1);
    checkOutput("jal_link",     pc_plus4,           32'h14);
    retire(1, 0, 0, 0, 32'h0);
    checkOutput("jal_pc_after", pc,                 32'h18);

    $display("[TB] branch");
    repeat (2) begin
      fetchWith(NOP, 0);
      retire(0, 0, 0, 0, 32'h0);
    end
    fetchWith(32'hFE00_0EE3, 0);
    checkOutput("br_imm_b",     imm_b,              32'hFFFF_FFFC);
    retire(0, 0, 1, 1, 32'h0);
    checkOutput("br_taken_pc",  pc,                 32'h1C);
    fetchWith(NOP, 0);
    retire(0, 0, 0, 0, 32'h0);
    fetchWith(32'hFE00_0EE3, 2);
    retire(0, 0, 1, 0, 32'h0);
    checkOutput("br_not_taken_pc", pc,              32'h24);

    $display("[TB] jalr");
    fetchWith(32'h0002_80E7, 0);
    retire(0, 1, 0, 0, 32'h101);
    checkOutput("jalr_pc",      pc,                 32'h100);
    checkOutput("jalr_mis",     32'(misalign),      32'd0);
    fetchWith(32'h0002_80E7, 0);
    retire(0, 1, 0, 0, 32'h102);
    checkOutput("jalr_trap_pc", pc,                 TRAP);
    checkOutput("jalr_mis_on",  32'(misalign),      32'd1);
    tick();
    checkOutput("jalr_mis_off", 32'(misalign),      32'd0);

    $display("[TB] reset during fetch");
    applyStimulus(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("rstack_instr", instr,              32'h13);
    checkOutput("rstack_pc",    pc,                 RST_PC);
    checkOutput("rstack_req",   32'(imem_req),      32'd0);
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("late_ack_req",   32'(imem_req),    32'd1);
    checkOutput("late_ack_instr", instr,            32'h13);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("late_ack_still_fetch", 32'(imem_req), 32'd1);

    $display("[TB] random phase");
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 2) == 0,
                    $urandom,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1,
                    $urandom);
    end
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFails);
    $finish;
  end

endmodule
